// File: rtl/instr_encoder.sv
// RV32 instruction-word encoder: packs raw fields into one of the R/I/S/B/U/J layouts,
// flags range/alignment faults, and tags each word with a word address from a running counter.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic [31:0] imm,
    input  logic        addr_clr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic [15:0] out_count,
    output logic [7:0]  err_count
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [6:0] OP_IMM = 7'b0010011;

    logic [31:0] enc_instr;
    logic        enc_err;
    logic        is_shift;
    logic        fits_12;
    logic        fits_13;
    logic        fits_21;
    logic        shamt_ok;

    logic        accept;
    logic        drain;
    logic [31:0] addr_cnt;
    logic [31:0] addr_inc;
    logic [31:0] capture_addr;

    // funct3 001 (slli) and 101 (srli/srai) are the only codes with low bits 01.
    assign is_shift = (opcode == OP_IMM) && (funct3[1:0] == 2'b01);

    // A value fits an N-bit signed field when all bits above N-1 replicate the sign bit.
    assign fits_12  = (&imm[31:11]) || !(|imm[31:11]);
    assign fits_13  = (&imm[31:12]) || !(|imm[31:12]);
    assign fits_21  = (&imm[31:20]) || !(|imm[31:20]);
    assign shamt_ok = !(|imm[31:5]);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        enc_instr = 32'h0000_0000;
        enc_err   = 1'b0;
        case (fmt)
            FMT_R: begin
                enc_instr = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            FMT_I: begin
                if (is_shift) begin
                    enc_instr = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                    enc_err   = !shamt_ok;
                end else begin
                    enc_instr = {imm[11:0], rs1, funct3, rd, opcode};
                    enc_err   = !fits_12;
                end
            end
            FMT_S: begin
                enc_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                enc_err   = !fits_12;
            end
            FMT_B: begin
                enc_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                enc_err   = !fits_13 || imm[0];
            end
            FMT_U: begin
                enc_instr = {imm[31:12], rd, opcode};
                enc_err   = |imm[11:0];
            end
            FMT_J: begin
                enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                enc_err   = !fits_21 || imm[0];
            end
            default: begin
                enc_err = 1'b1;
            end
        endcase
    end

    // Reset forces ready high so the upstream never stalls on a register being cleared.
    assign in_ready = rst || !out_valid || out_ready;

    assign accept       = in_valid && in_ready;
    assign drain        = out_valid && out_ready;
    assign addr_inc     = addr_cnt + 32'd4;
    assign capture_addr = drain ? addr_inc : addr_cnt;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            // NOTE: every register here is a plain flop, so all of them are reset.
            out_valid <= 1'b0;
            out_instr <= 32'h0000_0000;
            out_addr  <= 32'h0000_0000;
            out_err   <= 1'b0;
        end else if (in_valid) begin
            if (in_ready) begin
                out_valid <= 1'b1;
                out_instr <= enc_instr;
                out_addr  <= capture_addr;
                out_err   <= enc_err;
            end
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_cnt <= BASE_ADDR;
        end else if (addr_clr) begin
            addr_cnt <= BASE_ADDR;
        end else if (drain) begin
            addr_cnt <= addr_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_count <= 16'd0;
            err_count <= 8'd0;
        end else if (drain) begin
            out_count <= out_count + 16'd1;
            if (out_err && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed and randomized bench for instr_encoder; expected words come from an arithmetic
// reference of the instruction formats and a transaction-level model of the output register.
module tb_instr_encoder;

    localparam logic [31:0] BASE = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        addr_clr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;
    logic [15:0] out_count;
    logic [7:0]  err_count;

    int n_vec = 0;
    int n_err = 0;

    bit          m_valid = 1'b0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_addr  = '0;
    bit          m_err   = 1'b0;
    logic [31:0] m_cnt   = '0;
    int          m_count = 0;
    int          m_errs  = 0;

    int bnd_fmt [14] = '{1, 1, 1, 1, 1, 1, 1, 3, 3, 3, 5, 5, 5, 2};
    int bnd_op  [14] = '{3, 3, 3, 3, 19, 19, 19, 99, 99, 99, 111, 111, 111, 35};
    int bnd_f3  [14] = '{0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 2};
    int bnd_imm [14] = '{2047, -2048, 2048, -2049, 31, 32, -1, 4094, -4096, 4096,
                         1048574, -1048576, 1048576, -2049};

    always #5 clk = ~clk;

    instr_encoder #(.BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .imm       (imm),
        .addr_clr  (addr_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .out_err   (out_err),
        .out_count (out_count),
        .err_count (err_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Field placement computed with shifts and masks on the integer value of imm.
    function automatic void ref_encode(output logic [31:0] w, output logic e);
        longint v, r, op, f3, f7, a, b, d;
        v  = $signed(imm);
        op = opcode; f3 = funct3; f7 = funct7; a = rs1; b = rs2; d = rd;
        r  = 0;
        e  = 1'b0;
        case (fmt)
            3'd0: r = (f7 << 25) | (b << 20) | (a << 15) | (f3 << 12) | (d << 7) | op;
            3'd1: begin
                if (op == 19 && (f3 == 1 || f3 == 5)) begin
                    e = (v < 0) || (v > 31);
                    r = (f7 << 25) | ((v & 31) << 20) | (a << 15) | (f3 << 12) | (d << 7) | op;
                end else begin
                    e = (v < -2048) || (v > 2047);
                    r = ((v & 4095) << 20) | (a << 15) | (f3 << 12) | (d << 7) | op;
                end
            end
            3'd2: begin
                e = (v < -2048) || (v > 2047);
                r = (((v >> 5) & 127) << 25) | (b << 20) | (a << 15) | (f3 << 12)
                  | ((v & 31) << 7) | op;
            end
            3'd3: begin
                e = (v < -4096) || (v > 4094) || ((v & 1) != 0);
                r = (((v >> 12) & 1) << 31) | (((v >> 5) & 63) << 25) | (b << 20) | (a << 15)
                  | (f3 << 12) | (((v >> 1) & 15) << 8) | (((v >> 11) & 1) << 7) | op;
            end
            3'd4: begin
                e = (v & 4095) != 0;
                r = (v & 64'h0000_0000_FFFF_F000) | (d << 7) | op;
            end
            3'd5: begin
                e = (v < -1048576) || (v > 1048574) || ((v & 1) != 0);
                r = (((v >> 20) & 1) << 31) | (((v >> 1) & 1023) << 21) | (((v >> 11) & 1) << 20)
                  | (((v >> 12) & 255) << 12) | (d << 7) | op;
            end
            default: begin
                e = 1'b1;
                r = 0;
            end
        endcase
        w = r[31:0];
    endfunction

    task automatic put(input int f, input int op, input int f3, input int f7,
                       input int a, input int b, input int d, input int v);
        in_valid = 1'b1;
        fmt      = 3'(f);
        opcode   = 7'(op);
        funct3   = 3'(f3);
        funct7   = 7'(f7);
        rs1      = 5'(a);
        rs2      = 5'(b);
        rd       = 5'(d);
        imm      = 32'(v);
    endtask

    // One clock: check in_ready, advance the model with the current inputs, check registers.
    task automatic tick();
        logic [31:0] w;
        logic        e;
        bit          ready, fi, fo;
        logic [31:0] nxt;
        #1;
        ready = rst || !m_valid || out_ready;
        check("in_ready", 32'(in_ready), 32'(ready));
        ref_encode(w, e);
        if (rst) begin
            m_valid = 1'b0;
            m_cnt   = BASE;
            m_count = 0;
            m_errs  = 0;
        end else begin
            fi  = in_valid && ready;
            fo  = m_valid && out_ready;
            nxt = fo ? m_cnt + 32'd4 : m_cnt;
            if (fo) begin
                m_count = (m_count + 1) % 65536;
                if (m_err && m_errs < 255) m_errs++;
            end
            if (fi) begin
                m_valid = 1'b1;
                m_instr = w;
                m_err   = e;
                m_addr  = nxt;
            end else if (fo) begin
                m_valid = 1'b0;
            end
            m_cnt = addr_clr ? BASE : nxt;
        end
        @(posedge clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            check("out_instr", out_instr, m_instr);
            check("out_addr", out_addr, m_addr);
            check("out_err", 32'(out_err), 32'(m_err));
        end
        check("out_count", 32'(out_count), 32'(m_count));
        check("err_count", 32'(err_count), 32'(m_errs));
    endtask

    initial begin
        rst = 1'b1; addr_clr = 1'b0; out_ready = 1'b0;
        put(0, 51, 0, 0, 1, 2, 3, 0);
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_addr", out_addr, 32'd0);
        check("rst_err", 32'(out_err), 32'd0);

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();

        put(0, 51, 0, 0, 1, 2, 3, 0);
        tick();
        check("add_instr", out_instr, 32'h002081B3);
        check("add_addr", out_addr, BASE);
        check("add_err", 32'(out_err), 32'd0);

        in_valid = 1'b0; addr_clr = 1'b1;
        tick();
        addr_clr = 1'b0;
        put(1, 19, 0, 0, 0, 0, 1, -1);
        tick();
        check("addi_instr", out_instr, 32'hFFF00093);
        check("addi_addr", out_addr, BASE);
        put(3, 99, 0, 0, 0, 0, 0, -4);
        tick();
        check("beq_instr", out_instr, 32'hFE000EE3);
        check("beq_addr", out_addr, 32'hFFFF_FFFC);

        put(4, 55, 0, 0, 0, 0, 5, 32'h12345000);
        tick();
        check("lui_instr", out_instr, 32'h123452B7);
        check("lui_err", 32'(out_err), 32'd0);
        put(4, 55, 0, 0, 0, 0, 5, 32'h12345001);
        tick();
        check("lui_bad_err", 32'(out_err), 32'd1);
        in_valid = 1'b0;
        tick();
        check("lui_errcnt", 32'(err_count), 32'd1);

        put(3, 99, 0, 0, 0, 0, 0, 3);
        tick();
        check("b_odd_err", 32'(out_err), 32'd1);
        put(1, 3, 0, 0, 0, 0, 1, 2048);
        tick();
        check("i_2048_err", 32'(out_err), 32'd1);

        for (int i = 0; i < 14; i++) begin
            put(bnd_fmt[i], bnd_op[i], bnd_f3[i], 32, 7, 9, 11, bnd_imm[i]);
            tick();
        end
        put(6, 51, 0, 0, 1, 2, 3, 0);
        tick();
        check("fmt6_instr", out_instr, 32'd0);
        put(7, 51, 0, 0, 1, 2, 3, 0);
        tick();
        check("fmt7_err", 32'(out_err), 32'd1);

        for (int i = 0; i < 300; i++) begin
            put(3, 99, 0, 0, 0, 0, 0, 3);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("errcnt_sat", 32'(err_count), 32'd255);

        put(2, 35, 2, 0, 4, 5, 0, 100);
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            put(0, 51, 0, 32, 1, 2, 3 + i, 0);
            tick();
            check("stall_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            put(5, 111, 0, 0, 0, 0, i, 2 * i - 6);
            tick();
            check("stream_valid", 32'(out_valid), 32'd1);
        end

        out_ready = 1'b0; in_valid = 1'b0; addr_clr = 1'b1;
        tick();
        addr_clr = 1'b0;
        tick();

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_count", 32'(out_count), 32'd0);
        out_ready = 1'b1;
        put(0, 51, 0, 0, 1, 2, 3, 0);
        tick();
        check("midrst_addr", out_addr, BASE);

        for (int i = 0; i < 400; i++) begin
            put(int'($urandom_range(0, 7)), int'($urandom_range(0, 127)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 127)), int'($urandom_range(0, 31)),
                int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 0);
            if ($urandom_range(0, 3) == 0) opcode = 7'h13;
            case ($urandom_range(0, 3))
                0: imm = 32'(int'($urandom_range(0, 63)) - 32);
                1: imm = $urandom;
                2: imm = 32'(bnd_imm[$urandom_range(0, 13)]);
                default: imm = $urandom & 32'hFFFF_F000;
            endcase
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            addr_clr  = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0; addr_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the first instruction-memory word address emitted after reset or clear.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: in_valid  in  1  request carries a field set to encode.
REQ-005 SHALL have ports: in_ready  out  1  encoder accepts the request this cycle.
REQ-006 SHALL have ports: fmt  in  3  format select: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
REQ-007 SHALL have ports: opcode  in  7, funct3  in  3, funct7  in  7, rs1/rs2/rd  in  5 each  raw instruction fields.
REQ-008 SHALL have ports: imm  in  32  signed byte-offset or immediate value, unencoded.
REQ-009 SHALL have ports: addr_clr  in  1  reload the address counter to BASE_ADDR.
REQ-010 SHALL have ports: out_valid  out  1, out_ready  in  1  output handshake.
REQ-011 SHALL have ports: out_instr  out  32, out_addr  out  32, out_err  out  1  encoded word, its target address, and an encode-error flag.
REQ-012 SHALL have ports: out_count  out  16 (accepted outputs, wraps) and err_count  out  8 (erroneous outputs accepted, saturates at 255).

Function
REQ-013 SHALL hold a single output register; in_ready = !out_valid || out_ready (combinational).
REQ-014 SHALL load out_instr, out_err and out_addr = current addr counter one cycle after in_valid && in_ready, and SHALL assert out_valid that cycle (latency 1).
REQ-015 SHALL hold out_instr, out_addr and out_err stable while out_valid && !out_ready.
REQ-016 SHALL, on out_valid && out_ready: increment addr by 4 (mod 2^32), increment out_count by 1 (wrap), and increment err_count if out_err, saturating at 255.
REQ-017 SHALL support a simultaneous drain and accept in one cycle, with no bubble; the new word SHALL get the post-increment address.
REQ-018 SHALL encode R as {funct7,rs2,rs1,funct3,rd,opcode}.
REQ-019 SHALL encode I as {imm[11:0],rs1,funct3,rd,opcode}; the range is -2048..2047.
REQ-020 SHALL, for I with opcode 0010011 and funct3 001 or 101 (shifts), encode {funct7,imm[4:0],rs1,funct3,rd,opcode}; the range is 0..31.
REQ-021 SHALL encode S as {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}; the range is -2048..2047.
REQ-022 SHALL encode B as {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}; the range is -4096..4094, and imm[0] SHALL be 0.
REQ-023 SHALL encode U as {imm[31:12],rd,opcode}; imm[11:0] SHALL be 0.
REQ-024 SHALL encode J as {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}; the range is -1048576..1048574, and imm[0] SHALL be 0.
REQ-025 SHALL, on any range or alignment violation, still emit the truncated encoding with out_err=1.
REQ-026 SHALL, for illegal fmt, emit out_instr=32'h0000_0000 with out_err=1.
REQ-027 SHALL treat range checks as signed 32-bit comparisons on imm; unused input fields SHALL be ignored.
REQ-028 SHALL apply addr_clr to the counter only; the word held in the output register SHALL keep its captured out_addr.
REQ-029 SHALL give addr_clr priority over a same-cycle increment; the counter SHALL become BASE_ADDR.

Reset
REQ-030 SHALL, while rst=1 at a clock edge, set out_valid=0, out_instr=0, out_addr=0, out_err=0, addr=BASE_ADDR, out_count=0 and err_count=0.
REQ-031 SHALL, on reset mid-handshake, drop the pending word without counting it; in_ready SHALL read 1 the cycle after reset.
REQ-032 SHALL keep in_ready=1 during reset but capture nothing.

Verification
REQ-033 SHALL check: R, opcode 0110011, rd=3, rs1=1, rs2=2, funct3=0, funct7=0 -> out_instr 32'h002081B3, out_err=0, out_addr=BASE_ADDR.
REQ-034 SHALL check: I, opcode 0010011, rd=1, rs1=0, imm=-1, then B, opcode 1100011, imm=-4 -> 32'hFFF00093 then 32'hFE000EE3, out_addr BASE_ADDR then +4.
REQ-035 SHALL check: U, opcode 0110111, rd=5, imm=32'h12345000 -> 32'h123452B7; the same with imm=32'h12345001 -> out_err=1 and err_count=1.
REQ-036 SHALL check: B with imm=3, and I with imm=2048 -> both out_err=1; err_count saturates at 255 after 300 such words.
REQ-037 SHALL check: hold out_ready=0 for 3 cycles while in_valid=1 -> out_instr stable, in_ready=0, no counter change; then out_ready=1 -> one word per cycle, no bubble.
REQ-038 SHALL check: assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_count=0, and the next accepted word gets out_addr=BASE_ADDR.
